// File: rtl/aq_djpeg_idctb_fetch_if.sv
// aq_djpeg_idctb_fetch_if: ordered coefficient-pair stream
// toward the column-pass IDCT, valid/ready handshake.
interface aq_djpeg_idctb_fetch_if;
  logic        OutValid;
  logic        OutReady;
  logic [2:0]  OutPage;
  logic [1:0]  OutCount;
  logic        OutLast;
  logic [15:0] OutA;
  logic [15:0] OutB;

  modport master (
    output OutValid,
    output OutPage,
    output OutCount,
    output OutLast,
    output OutA,
    output OutB,
    input  OutReady
  );

  modport slave (
    input  OutValid,
    input  OutPage,
    input  OutCount,
    input  OutLast,
    input  OutA,
    input  OutB,
    output OutReady
  );
endinterface

// File: rtl/aq_djpeg_idctb_fetch.sv
// aq_djpeg_idctb_fetch: transpose-buffer read sequencer
// with lane-swap correction and credit-based output FIFO.
module aq_djpeg_idctb_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataInit,
  input  logic        BufEnable,
  output logic        BufRead,
  output logic [4:0]  BufAddress,
  input  logic [15:0] BufDataA,
  input  logic [15:0] BufDataB,
  aq_djpeg_idctb_fetch_if.master out
);

  localparam int PW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];

  logic [4:0]    addr;
  logic [4:0]    issAddr;
  logic          inflight;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          wr;
  logic          pop;
  logic          swap;
  logic [15:0]   capA;
  logic [15:0]   capB;
  logic [4:0]    headAddr;

  logic [4:0]  fAddr [FIFO_DEPTH];
  logic [15:0] fA    [FIFO_DEPTH];
  logic [15:0] fB    [FIFO_DEPTH];

  // Reads in flight count against FIFO space so
  // a capture always has a free slot.
  assign used = {1'b0, count} +
                {{CW{1'b0}}, inflight};
  assign BufRead = rst & BufEnable & ~DataInit &
                   (used < DEPTH);
  assign BufAddress = addr;

  // Buffer muxes lanes with the live address, so a
  // bit-4 change since issue means lanes arrive swapped.
  assign swap = addr[4] ^ issAddr[4];
  assign capA = swap ? BufDataB : BufDataA;
  assign capB = swap ? BufDataA : BufDataB;

  assign wr  = inflight & ~DataInit;
  assign pop = out.OutValid & out.OutReady;

  // Address walk and one-deep in-flight tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      issAddr  <= '0;
      inflight <= 1'b0;
    end else if (DataInit) begin
      addr     <= '0;
      inflight <= 1'b0;
    end else if (BufRead) begin
      addr     <= addr + 5'd1;
      issAddr  <= addr;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (DataInit) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wr)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, zeroed on reset so an empty head reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fAddr[i] <= '0;
        fA[i]    <= '0;
        fB[i]    <= '0;
      end
    end else if (wr) begin
      fAddr[wrPtr] <= issAddr;
      fA[wrPtr]    <= capA;
      fB[wrPtr]    <= capB;
    end
  end

  // A capture into a full FIFO means credit accounting broke.
  always_ff @(posedge clk) begin
    if (rst && wr)
      assert ({1'b0, count} < DEPTH);
  end

  assign headAddr     = fAddr[rdPtr];
  assign out.OutValid = (count != '0);
  assign out.OutPage  = headAddr[4:2];
  assign out.OutCount = headAddr[1:0];
  assign out.OutLast  = (headAddr == 5'd31);
  assign out.OutA     = fA[rdPtr];
  assign out.OutB     = fB[rdPtr];

endmodule

// File: tb/tb_aq_djpeg_idctb_fetch.sv
// tb_aq_djpeg_idctb_fetch: directed vectors plus a
// transpose-buffer model and in-order pair scoreboard.
module tb_aq_djpeg_idctb_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DataInit = 1'b0;
  logic        BufEnable;
  logic        BufRead;
  logic [4:0]  BufAddress;
  logic [15:0] BufDataA;
  logic [15:0] BufDataB;

  logic        direct = 1'b1;
  logic        tEn = 1'b0;
  logic [15:0] tDa = '0;
  logic [15:0] tDb = '0;
  logic        enGate = 1'b0;

  int banksAdded = 0;
  int banksDone = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int reads = 0;
  int lastReads = 0;
  int pops = 0;
  int lastPop = 0;
  int expN = 0;
  int expBank = 0;
  bit monOn = 1'b0;

  logic [15:0] r0 = '0;
  logic [15:0] r1 = '0;
  logic [15:0] pa;
  logic [15:0] pb;

  aq_djpeg_idctb_fetch_if ob ();

  aq_djpeg_idctb_fetch #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .DataInit  (DataInit),
    .BufEnable (BufEnable),
    .BufRead   (BufRead),
    .BufAddress(BufAddress),
    .BufDataA  (BufDataA),
    .BufDataB  (BufDataB),
    .out       (ob)
  );

  always #5 clk = ~clk;

  // Buffer model: upper-half pairs stored lane-swapped,
  // output mux follows the live address bit 4.
  assign pa = 16'h1000 + 16'(banksDone * 256) +
              {11'd0, BufAddress};
  assign pb = 16'h2000 + 16'(banksDone * 256) +
              {11'd0, BufAddress};
  always @(posedge clk) begin
    if (BufRead) begin
      r0 <= BufAddress[4] ? pb : pa;
      r1 <= BufAddress[4] ? pa : pb;
      if (BufAddress == 5'd31)
        banksDone <= banksDone + 1;
    end
  end

  assign BufEnable = direct ? tEn :
         (enGate && (banksAdded > banksDone));
  assign BufDataA = direct ? tDa :
         (BufAddress[4] ? r1 : r0);
  assign BufDataB = direct ? tDb :
         (BufAddress[4] ? r0 : r1);

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Scoreboard: every pop must be the next pair in order.
  always @(negedge clk) begin : mon
    logic [15:0] ea;
    logic [15:0] eb;
    logic [4:0]  en;
    if (BufRead) begin
      reads++;
      if (BufAddress == 5'd31)
        lastReads++;
    end
    if (monOn && ob.OutValid && ob.OutReady) begin
      en = expN[4:0];
      ea = 16'h1000 + 16'(expBank * 256 + expN);
      eb = 16'h2000 + 16'(expBank * 256 + expN);
      check("pop",
            {ob.OutPage, ob.OutCount, ob.OutLast,
             ob.OutA, ob.OutB},
            {en, (en == 5'd31), ea, eb});
      pops++;
      lastPop = cyc;
      expN++;
      if (expN == 32) begin
        expN = 0;
        expBank++;
      end
    end
  end

  typedef struct {
    logic        en;
    logic        rdy;
    logic        init;
    logic [15:0] da;
    logic [15:0] db;
    logic        rd;
    logic [4:0]  ad;
    logic        vl;
    logic [4:0]  hd;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ch;
  } vec_t;

  function automatic vec_t mk(
    logic en, logic rdy, logic init,
    logic [15:0] da, logic [15:0] db,
    logic rd, logic [4:0] ad, logic vl,
    logic [4:0] hd, logic [15:0] ea,
    logic [15:0] eb, logic ch);
    vec_t v;
    v.en = en; v.rdy = rdy; v.init = init;
    v.da = da; v.db = db;
    v.rd = rd; v.ad = ad; v.vl = vl;
    v.hd = hd; v.ea = ea; v.eb = eb;
    v.ch = ch;
    return v;
  endfunction

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [11];
    int p0;
    int r0c;
    int l0;
    int fr;
    int fv;
    bit stable;
    bit have;
    logic [37:0] snap;
    logic [37:0] cur;

    tbl[0]  = mk(0,0,0,16'h0,16'h0,
                 0,5'd0,0,5'd0,16'h0,16'h0,1);
    tbl[1]  = mk(1,0,0,16'h0,16'h0,
                 1,5'd0,0,5'd0,16'h0,16'h0,0);
    tbl[2]  = mk(1,0,0,16'hA000,16'hB000,
                 1,5'd1,0,5'd0,16'h0,16'h0,0);
    tbl[3]  = mk(1,0,0,16'hA001,16'hB001,
                 1,5'd2,1,5'd0,16'hA000,16'hB000,1);
    tbl[4]  = mk(0,0,0,16'hA002,16'hB002,
                 0,5'd3,1,5'd0,16'hA000,16'hB000,1);
    tbl[5]  = mk(1,1,0,16'h0,16'h0,
                 1,5'd3,1,5'd0,16'hA000,16'hB000,1);
    tbl[6]  = mk(1,1,0,16'hA003,16'hB003,
                 1,5'd4,1,5'd1,16'hA001,16'hB001,1);
    tbl[7]  = mk(0,0,0,16'hA004,16'hB004,
                 0,5'd5,1,5'd2,16'hA002,16'hB002,1);
    tbl[8]  = mk(0,1,0,16'h0,16'h0,
                 0,5'd5,1,5'd2,16'hA002,16'hB002,1);
    tbl[9]  = mk(1,0,1,16'h0,16'h0,
                 0,5'd5,1,5'd3,16'hA003,16'hB003,1);
    tbl[10] = mk(0,0,0,16'h0,16'h0,
                 0,5'd0,0,5'd0,16'h0,16'h0,0);

    ob.OutReady = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tEn = tbl[i].en;
      ob.OutReady = tbl[i].rdy;
      DataInit = tbl[i].init;
      tDa = tbl[i].da;
      tDb = tbl[i].db;
      #1;
      check($sformatf("vec%0d_ctl", i),
            {BufRead, BufAddress, ob.OutValid},
            {tbl[i].rd, tbl[i].ad, tbl[i].vl});
      if (tbl[i].ch)
        check($sformatf("vec%0d_data", i),
              {ob.OutPage, ob.OutCount, ob.OutLast,
               ob.OutA, ob.OutB},
              {tbl[i].hd, 1'b0,
               tbl[i].ea, tbl[i].eb});
      tick();
    end
    tEn = 1'b0;
    DataInit = 1'b0;
    direct = 1'b0;
    enGate = 1'b1;
    monOn = 1'b1;

    // One bank, consumer always ready.
    doReset();
    ob.OutReady = 1'b1;
    expN = 0;
    expBank = banksDone;
    p0 = pops;
    l0 = lastReads;
    fr = -1;
    fv = -1;
    banksAdded = banksDone + 1;
    for (int k = 0; k < 80 && (pops - p0) < 32; k++) begin
      #1;
      if (BufRead && fr < 0) fr = cyc;
      if (ob.OutValid && fv < 0) fv = cyc;
      tick();
    end
    check("bank_pops", 64'(pops - p0), 64'd32);
    check("first_latency", 64'(fv - fr), 64'd2);
    check("block_span", 64'(lastPop - fr), 64'd33);
    check("bank_last_reads", 64'(lastReads - l0), 64'd1);

    // Backpressure: hold consumer off for 20 cycles.
    doReset();
    ob.OutReady = 1'b0;
    expN = 0;
    expBank = banksDone;
    r0c = reads;
    stable = 1'b1;
    have = 1'b0;
    snap = '0;
    banksAdded = banksDone + 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      cur = {ob.OutPage, ob.OutCount, ob.OutLast,
             ob.OutA, ob.OutB};
      if (ob.OutValid) begin
        if (!have) begin
          have = 1'b1;
          snap = cur;
        end else if (cur !== snap) begin
          stable = 1'b0;
        end
      end else if (have) begin
        stable = 1'b0;
      end
      tick();
    end
    check("bp_reads", 64'(reads - r0c), 64'd4);
    check("bp_stable", {62'd0, have, stable}, 64'd3);
    check("bp_head", 64'(snap),
          {26'd0, 5'd0, 1'b0,
           16'h1000 + 16'(expBank * 256),
           16'h2000 + 16'(expBank * 256)});
    ob.OutReady = 1'b1;
    p0 = pops;
    for (int k = 0; k < 80 && (pops - p0) < 32; k++)
      tick();
    check("bp_pops", 64'(pops - p0), 64'd32);
    check("bp_reads_total", 64'(reads - r0c), 64'd32);

    // Two banks with a toggling consumer.
    doReset();
    expN = 0;
    expBank = banksDone;
    p0 = pops;
    l0 = lastReads;
    r0c = reads;
    banksAdded = banksDone + 2;
    for (int k = 0; k < 300 && (pops - p0) < 64; k++) begin
      #1;
      ob.OutReady = cyc[0];
      tick();
    end
    check("two_pops", 64'(pops - p0), 64'd64);
    check("two_last_reads", 64'(lastReads - l0), 64'd2);
    check("two_reads", 64'(reads - r0c), 64'd64);
    check("two_addr_wrap", 64'(BufAddress), 64'd0);

    // Flush at pair 10 with pairs 10 and 11 buffered.
    doReset();
    ob.OutReady = 1'b1;
    expN = 0;
    expBank = banksDone;
    p0 = pops;
    r0c = reads;
    banksAdded = banksDone + 1;
    for (int k = 0; k < 80 &&
         !((pops - p0) >= 10 && (reads - r0c) >= 12);
         k++) begin
      #1;
      if ((reads - r0c) >= 12) enGate = 1'b0;
      if ((pops - p0) >= 10) ob.OutReady = 1'b0;
      tick();
    end
    enGate = 1'b0;
    ob.OutReady = 1'b0;
    tick();
    tick();
    tick();
    check("init_pre_head",
          {ob.OutValid, ob.OutPage, ob.OutCount},
          {1'b1, 5'd10});
    DataInit = 1'b1;
    enGate = 1'b1;
    #1;
    check("init_no_read", 64'(BufRead), 64'd0);
    tick();
    DataInit = 1'b0;
    expN = 0;
    #1;
    check("init_after",
          {ob.OutValid, BufAddress},
          {1'b0, 5'd0});
    ob.OutReady = 1'b1;
    p0 = pops;
    for (int k = 0; k < 80 && (pops - p0) < 32; k++)
      tick();
    check("init_restart_pops", 64'(pops - p0), 64'd32);

    // Async reset right after pair 20 issues.
    doReset();
    ob.OutReady = 1'b1;
    expN = 0;
    expBank = banksDone;
    r0c = reads;
    banksAdded = banksDone + 1;
    for (int k = 0; k < 80 && (reads - r0c) < 21; k++)
      tick();
    check("rst_mid_addr", 64'(BufAddress), 64'd21);
    rst = 1'b0;
    expN = 0;
    #1;
    check("rst_mid_outputs",
          {BufRead, BufAddress, ob.OutValid,
           ob.OutPage, ob.OutCount, ob.OutLast,
           ob.OutA, ob.OutB},
          64'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rst_restart",
          {BufRead, BufAddress}, {1'b1, 5'd0});
    p0 = pops;
    for (int k = 0; k < 80 && (pops - p0) < 32; k++)
      tick();
    check("rst_restart_pops", 64'(pops - p0), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
